// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO drain path: serializer FSM states and
// lane geometry helpers.
package fifo_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } ser_state_t;

  // Number of OUTWIDTH lanes carried by one DATAWIDTH word.
  function automatic int ser_nlanes(input int dw, input int ow);
    return dw / ow;
  endfunction

  // Width of the lane index counter; at least one bit.
  function automatic int ser_cnt_width(input int dw, input int ow);
    return ((dw / ow) > 1) ? $clog2(dw / ow) : 1;
  endfunction

endpackage

// File: rtl/fifo_byte_serializer.sv
// Drain stage for the synchronous FIFO: pops words from the FWFT read port
// and emits them lane by lane on a valid/ready stream, flagging the last
// lane of each word. Back-to-back words are sent without a bubble.
module fifo_byte_serializer
  import fifo_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int OUTWIDTH  = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 fifo_empty,
  input  logic [DATAWIDTH-1:0] fifo_rd_data,
  output logic                 fifo_rd_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUTWIDTH-1:0]  out_data,
  output logic                 out_last,
  output logic [15:0]          word_count
);

  localparam int NLANES = ser_nlanes(DATAWIDTH, OUTWIDTH);
  localparam int CNT_W  = ser_cnt_width(DATAWIDTH, OUTWIDTH);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NLANES - 1);

  // Reject lane geometries that do not split a word evenly into >= 2 lanes.
  if (((DATAWIDTH % OUTWIDTH) != 0) || (NLANES < 2)) begin : g_bad_cfg
    $error("fifo_byte_serializer: DATAWIDTH must be a multiple of OUTWIDTH with at least 2 lanes");
  end

  ser_state_t           state_q, state_next;
  logic [DATAWIDTH-1:0] word_q, word_next;
  logic [CNT_W-1:0]     cnt_q, cnt_next;
  logic [15:0]          word_count_q, word_count_next;
  logic [CNT_W-1:0]     lane_sel;
  logic                 last_lane;

  assign last_lane  = (cnt_q == LAST_LANE);
  assign lane_sel   = (MSB_FIRST != 0) ? (LAST_LANE - cnt_q) : cnt_q;
  assign word_count = word_count_q;

  // Pop is combinational so a refill lands on the same edge as the final
  // lane accept; it never fires on an empty FIFO or while in reset.
  assign fifo_rd_en = rstn & ~fifo_empty &
                      ((state_q == S_IDLE) | ((state_q == S_SEND) & out_ready & last_lane));

  // State, held word, lane index and word counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      word_q       <= '0;
      cnt_q        <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_next;
      word_q       <= word_next;
      cnt_q        <= cnt_next;
      word_count_q <= word_count_next;
    end
  end

  // Next-state and stream outputs: advance one lane per accept, reload on pop.
  always_comb begin
    state_next      = state_q;
    word_next       = word_q;
    cnt_next        = cnt_q;
    word_count_next = word_count_q;
    out_valid       = 1'b0;
    out_data        = '0;
    out_last        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fifo_rd_en) begin
          word_next  = fifo_rd_data;
          cnt_next   = '0;
          state_next = S_SEND;
        end
      end
      S_SEND: begin
        out_valid = 1'b1;
        out_data  = word_q[int'(lane_sel) * OUTWIDTH +: OUTWIDTH];
        out_last  = last_lane;
        if (out_ready) begin
          if (!last_lane) begin
            cnt_next = cnt_q + 1'b1;
          end else begin
            word_count_next = word_count_q + 16'd1;
            if (fifo_rd_en) begin
              word_next = fifo_rd_data;
              cnt_next  = '0;
            end else begin
              state_next = S_IDLE;
            end
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule
